sprite_scan_ctrl: RTL and testbench

Sequences the 10-slot sprite store during the OAM scan period of each scanline. It steps through all OAM entries, compares each entry's Y coordinate against the current line, and writes matching entries into the store. Each write places the OAM entry index and the sprite row offset into the next free slot, in OAM order, until all slots are full. It sits between the OAM read port, the LCD line counter and the sprite store's per-slot write strobes.

---
 rtl/sprite_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_sprite_scan_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_scan_ctrl.sv
// sprite_scan_ctrl
//   Walks all OAM entries once per scanline. Each entry takes two cycles:
//   ADDR (index presented) and CMP (Y byte compared against the line). Entries
//   whose rows cover the current line are written, in OAM order, into the
//   next free slot of the sprite store until every slot is full.
//
// Ports
//   clk, nrst      clock, asynchronous active-low reset
//   lcd_on         LCD enable; low aborts any scan and holds the block idle
//   scan_start     start-of-line pulse; begins (or restarts) a scan
//   ly             current line number
//   obj_tall       sprite height select (0: 8 rows, 1: 16 rows), latched at start
//   oam_y          Y byte of the addressed OAM entry, valid in CMP
//   oam_idx        OAM entry index being scanned
//   oam_rd         OAM read request (ADDR and CMP)
//   scan_busy      high from the first ADDR through the last CMP
//   scan_done      one-cycle pulse after a complete scan
//   store_we       one-hot slot write strobe (registered)
//   store_idx      OAM index to store
//   store_line     sprite row offset to store
//   sprite_count   slots filled on the current line
module sprite_scan_ctrl #(
  parameter int unsigned NUM_ENTRIES = 40,
  parameter int unsigned NUM_SLOTS   = 10,
  parameter int unsigned Y_OFFSET    = 16
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 lcd_on,
  input  logic                 scan_start,
  input  logic [7:0]           ly,
  input  logic                 obj_tall,
  input  logic [7:0]           oam_y,
  output logic [5:0]           oam_idx,
  output logic                 oam_rd,
  output logic                 scan_busy,
  output logic                 scan_done,
  output logic [NUM_SLOTS-1:0] store_we,
  output logic [5:0]           store_idx,
  output logic [3:0]           store_line,
  output logic [3:0]           sprite_count
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    CMP,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [5:0]           oam_idx_q, oam_idx_d;
  logic [3:0]           count_q, count_d;
  logic [NUM_SLOTS-1:0] store_we_q, store_we_d;
  logic [5:0]           store_idx_q, store_idx_d;
  logic [3:0]           store_line_q, store_line_d;
  logic                 tall_q, tall_d;

  logic [8:0]           diff;
  logic                 hit;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      oam_idx_q    <= '0;
      count_q      <= '0;
      store_we_q   <= '0;
      store_idx_q  <= '0;
      store_line_q <= '0;
      tall_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      oam_idx_q    <= oam_idx_d;
      count_q      <= count_d;
      store_we_q   <= store_we_d;
      store_idx_q  <= store_idx_d;
      store_line_q <= store_line_d;
      tall_q       <= tall_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    oam_idx_d    = oam_idx_q;
    count_d      = count_q;
    store_we_d   = '0;
    store_idx_d  = store_idx_q;
    store_line_d = store_line_q;
    tall_d       = tall_q;

    // A negative difference wraps and sets bit 8, so it can never hit.
    diff = {1'b0, ly} + 9'(Y_OFFSET) - {1'b0, oam_y};
    hit  = !diff[8] && (diff < (tall_q ? 9'd16 : 9'd8));

    // Abort and restart both override normal sequencing; since store_we_d
    // defaults to zero here, a write pending from the current CMP is dropped.
    if (!lcd_on) begin
      state_d = IDLE;
      count_d = '0;
    end else if (scan_start) begin
      state_d   = ADDR;
      oam_idx_d = '0;
      count_d   = '0;
      tall_d    = obj_tall;
    end else begin
      unique case (state_q)
        IDLE: ;
        ADDR: state_d = CMP;
        CMP: begin
          if (hit && (count_q < 4'(NUM_SLOTS))) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
              store_we_d[i] = (count_q == 4'(i));
            end
            store_idx_d  = oam_idx_q;
            store_line_d = diff[3:0];
            count_d      = count_q + 4'd1;
          end
          if (oam_idx_q == 6'(NUM_ENTRIES - 1)) begin
            state_d = DONE;
          end else begin
            oam_idx_d = oam_idx_q + 6'd1;
            state_d   = ADDR;
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign oam_idx      = oam_idx_q;
  assign oam_rd       = (state_q == ADDR) || (state_q == CMP);
  assign scan_busy    = (state_q == ADDR) || (state_q == CMP);
  assign scan_done    = (state_q == DONE);
  assign store_we     = store_we_q;
  assign store_idx    = store_idx_q;
  assign store_line   = store_line_q;
  assign sprite_count = count_q;

endmodule

// File: tb/tb_sprite_scan_ctrl.sv
module tb_sprite_scan_ctrl;

  localparam int NE = 40;
  localparam int NS = 10;

  logic          clk = 1'b0;
  logic          nrst;
  logic          lcd_on;
  logic          scan_start;
  logic [7:0]    ly;
  logic          obj_tall;
  logic [7:0]    oam_y;
  logic [5:0]    oam_idx;
  logic          oam_rd;
  logic          scan_busy;
  logic          scan_done;
  logic [NS-1:0] store_we;
  logic [5:0]    store_idx;
  logic [3:0]    store_line;
  logic [3:0]    sprite_count;

  logic [7:0]    mem [0:63];

  always #5 clk = ~clk;

  // OAM: the Y byte follows the presented index
  assign oam_y = mem[oam_idx];

  sprite_scan_ctrl #(
    .NUM_ENTRIES(NE),
    .NUM_SLOTS  (NS),
    .Y_OFFSET   (16)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .lcd_on      (lcd_on),
    .scan_start  (scan_start),
    .ly          (ly),
    .obj_tall    (obj_tall),
    .oam_y       (oam_y),
    .oam_idx     (oam_idx),
    .oam_rd      (oam_rd),
    .scan_busy   (scan_busy),
    .scan_done   (scan_done),
    .store_we    (store_we),
    .store_idx   (store_idx),
    .store_line  (store_line),
    .sprite_count(sprite_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // mode 0: after reset, 1: scan in progress/finished (rel = cycle since start),
  // 2: aborted by lcd_on low
  int mode = 0;
  int rel  = 0;
  int nw   = 0;
  int wcyc  [NS];
  int widx  [NS];
  int wline [NS];

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected slot writes: k-th hitting entry e (k < NS) appears two cycles
  // after its ADDR cycle, i.e. in cycle 2e+3 counted from the start edge.
  function automatic void build_model();
    int d, h;
    nw = 0;
    h  = obj_tall ? 16 : 8;
    for (int e = 0; e < NE; e++) begin
      d = int'(ly) + 16 - int'(mem[e]);
      if (d >= 0 && d < h && nw < NS) begin
        wcyc[nw]  = 2 * e + 3;
        widx[nw]  = e;
        wline[nw] = d;
        nw++;
      end
    end
  endfunction

  always @(posedge clk) begin
    if (!nrst) mode = 0;
    else if (!lcd_on) begin
      if (mode == 1) mode = 2;
    end else if (scan_start) begin
      mode = 1;
      rel  = 1;
      build_model();
    end else if (mode == 1) rel++;
  end

  always @(negedge clk) begin
    int e_we, e_cnt, c;
    bit busy_e;
    if (mode == 1) begin
      c     = rel;
      e_we  = 0;
      e_cnt = 0;
      for (int k = 0; k < nw; k++) begin
        if (wcyc[k] <= c) e_cnt++;
        if (wcyc[k] == c) begin
          e_we = 1 << k;
          chk("store_idx", int'(store_idx), widx[k]);
          chk("store_line", int'(store_line), wline[k]);
        end
      end
      busy_e = (c >= 1 && c <= 80);
      chk("scan_busy", int'(scan_busy), int'(busy_e));
      chk("oam_rd", int'(oam_rd), int'(busy_e));
      chk("scan_done", int'(scan_done), int'(c == 81));
      chk("store_we", int'(store_we), e_we);
      chk("sprite_count", int'(sprite_count), e_cnt);
      if (busy_e) chk("oam_idx", int'(oam_idx), (c - 1) / 2);
    end else begin
      chk("idle_busy", int'(scan_busy), 0);
      chk("idle_rd", int'(oam_rd), 0);
      chk("idle_done", int'(scan_done), 0);
      chk("idle_we", int'(store_we), 0);
      chk("idle_count", int'(sprite_count), 0);
      if (mode == 0) chk("idle_idx", int'(oam_idx), 0);
    end
  end

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 64; i++) mem[i] = v;
  endtask

  task automatic start_scan(input logic [7:0] l, input logic t);
    @(negedge clk);
    ly         = l;
    obj_tall   = t;
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
  endtask

  task automatic wait_rel(input int c);
    int n = 0;
    while (!(mode == 1 && rel == c) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_rel: got timeout, expected cycle %0d", c);
    end
  endtask

  task automatic pin_zero(input string tag);
    chk({tag, "_we"}, int'(store_we), 0);
    chk({tag, "_sidx"}, int'(store_idx), 0);
    chk({tag, "_sline"}, int'(store_line), 0);
    chk({tag, "_count"}, int'(sprite_count), 0);
    chk({tag, "_idx"}, int'(oam_idx), 0);
    chk({tag, "_busy"}, int'(scan_busy), 0);
    chk({tag, "_rd"}, int'(oam_rd), 0);
    chk({tag, "_done"}, int'(scan_done), 0);
  endtask

  initial begin
    nrst       = 1'b0;
    lcd_on     = 1'b1;
    scan_start = 1'b0;
    ly         = 8'd0;
    obj_tall   = 1'b0;
    fill(8'd0);
    repeat (2) @(negedge clk);
    pin_zero("reset");
    nrst = 1'b1;

    // no hits anywhere
    start_scan(8'd0, 1'b0);
    wait_rel(80);
    chk("t1_busy80", int'(scan_busy), 1);
    wait_rel(81);
    chk("t1_done81", int'(scan_done), 1);
    chk("t1_count", int'(sprite_count), 0);
    wait_rel(82);
    chk("t1_done82", int'(scan_done), 0);

    // two 8-row hits
    fill(8'd0);
    mem[3] = 8'd30;
    mem[7] = 8'd30;
    start_scan(8'd20, 1'b0);
    wait_rel(9);
    chk("t2_we_a", int'(store_we), 'h001);
    chk("t2_idx_a", int'(store_idx), 3);
    chk("t2_line_a", int'(store_line), 6);
    wait_rel(17);
    chk("t2_we_b", int'(store_we), 'h002);
    chk("t2_idx_b", int'(store_idx), 7);
    chk("t2_line_b", int'(store_line), 6);
    wait_rel(82);
    chk("t2_count", int'(sprite_count), 2);

    // height and boundary cases
    fill(8'd0);
    mem[0] = 8'd25;
    mem[5] = 8'd36;
    mem[6] = 8'd37;
    start_scan(8'd20, 1'b1);
    wait_rel(3);
    chk("t3_tall_we", int'(store_we), 'h001);
    chk("t3_tall_line", int'(store_line), 11);
    wait_rel(13);
    chk("t3_d0_we", int'(store_we), 'h002);
    chk("t3_d0_idx", int'(store_idx), 5);
    chk("t3_d0_line", int'(store_line), 0);
    wait_rel(15);
    chk("t3_neg_we", int'(store_we), 0);
    wait_rel(82);
    chk("t3_count", int'(sprite_count), 2);

    start_scan(8'd20, 1'b0);
    wait_rel(3);
    chk("t3s_we", int'(store_we), 0);
    wait_rel(13);
    chk("t3s_d0_we", int'(store_we), 'h001);
    chk("t3s_d0_idx", int'(store_idx), 5);
    wait_rel(82);
    chk("t3s_count", int'(sprite_count), 1);

    // every entry hits: slots saturate
    fill(8'd30);
    start_scan(8'd20, 1'b0);
    wait_rel(21);
    chk("t4_we9", int'(store_we), 'h200);
    chk("t4_idx9", int'(store_idx), 9);
    chk("t4_cnt9", int'(sprite_count), 10);
    wait_rel(23);
    chk("t4_we10", int'(store_we), 0);
    wait_rel(81);
    chk("t4_done", int'(scan_done), 1);
    chk("t4_count", int'(sprite_count), 10);

    // hit on the last entry coincides with scan_done
    fill(8'd0);
    mem[39] = 8'd30;
    start_scan(8'd20, 1'b0);
    wait_rel(81);
    chk("t5_we", int'(store_we), 'h001);
    chk("t5_done", int'(scan_done), 1);
    chk("t5_idx", int'(store_idx), 39);
    wait_rel(82);
    chk("t5_count", int'(sprite_count), 1);

    // restart during a CMP with a pending write
    fill(8'd30);
    start_scan(8'd20, 1'b0);
    wait_rel(6);
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    chk("rs_we", int'(store_we), 0);
    chk("rs_count", int'(sprite_count), 0);
    chk("rs_idx", int'(oam_idx), 0);
    chk("rs_busy", int'(scan_busy), 1);
    wait_rel(81);
    chk("rs_done", int'(scan_done), 1);
    chk("rs_final", int'(sprite_count), 10);

    // lcd_on abort, scan_start ignored while off, then full rescan
    start_scan(8'd20, 1'b0);
    wait_rel(30);
    lcd_on = 1'b0;
    @(negedge clk);
    chk("ab_busy", int'(scan_busy), 0);
    chk("ab_count", int'(sprite_count), 0);
    chk("ab_rd", int'(oam_rd), 0);
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    chk("ab_ign_busy", int'(scan_busy), 0);
    repeat (3) @(negedge clk);
    lcd_on = 1'b1;
    repeat (4) @(negedge clk);
    start_scan(8'd20, 1'b0);
    chk("ab_rs_idx", int'(oam_idx), 0);
    wait_rel(81);
    chk("ab_rs_count", int'(sprite_count), 10);

    // asynchronous reset mid-scan
    start_scan(8'd20, 1'b0);
    wait_rel(25);
    #1 nrst = 1'b0;
    mode = 0;
    #1 pin_zero("mrst");
    @(negedge clk);
    nrst = 1'b1;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
